// File: rtl/led_switch_pio.sv
// Avalon-MM peripheral for the board LEDs and slide switches: debounced switch inputs,
// edge capture with a maskable level IRQ, and per-LED hardware blink.
module led_switch_pio #(
    parameter int N_LED      = 8,
    parameter int N_SW       = 4,
    parameter int DEB_CYCLES = 50000,
    parameter int DIV_W      = 24,
    parameter int EDGE_MODE  = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset_n,
    input  logic [2:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic [N_LED-1:0] led_array_export,
    input  logic [N_SW-1:0]  sw_array_export,
    output logic             irq
);

    localparam int CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [N_LED-1:0] led_data;
    logic [N_LED-1:0] led_blink;
    logic [DIV_W-1:0] blink_div;
    logic [DIV_W-1:0] blink_cnt;
    logic             phase;
    logic [N_SW-1:0]  sync1;
    logic [N_SW-1:0]  sync2;
    logic [N_SW-1:0]  stable;
    logic [CNT_W-1:0] deb_cnt [N_SW];
    logic [N_SW-1:0]  accept;
    logic [N_SW-1:0]  edge_set;
    logic [N_SW-1:0]  edge_cap;
    logic [N_SW-1:0]  irq_mask;
    logic [N_SW-1:0]  cap_clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^avs_writedata;

    logic wr_led, wr_blink, wr_div, wr_cap, wr_mask;
    assign wr_led   = avs_write && (avs_address == 3'd0);
    assign wr_blink = avs_write && (avs_address == 3'd1);
    assign wr_div   = avs_write && (avs_address == 3'd2);
    assign wr_cap   = avs_write && (avs_address == 3'd4);
    assign wr_mask  = avs_write && (avs_address == 3'd5);

    assign cap_clr = wr_cap ? avs_writedata[N_SW-1:0] : '0;

    // A switch is accepted on the edge where its counter expires while the synced level still differs.
    always_comb begin
        accept = '0;
        for (int i = 0; i < N_SW; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (deb_cnt[i] == CNT_LAST);
        end
    end

    always_comb begin
        edge_set = '0;
        case (EDGE_MODE)
            0:       edge_set = accept & sync2;
            1:       edge_set = accept & ~sync2;
            default: edge_set = accept;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            for (int i = 0; i < N_SW; i++) deb_cnt[i] <= '0;
        end else begin
            sync1 <= sw_array_export;
            sync2 <= sync1;
            for (int i = 0; i < N_SW; i++) begin
                if (sync2[i] == stable[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    stable[i]  <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // A new edge beats a simultaneous W1C of the same bit.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            edge_cap <= '0;
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | edge_set;
            if (wr_mask) irq_mask <= avs_writedata[N_SW-1:0];
            irq <= |(edge_cap & irq_mask);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            led_data         <= '0;
            led_blink        <= '0;
            blink_div        <= '0;
            blink_cnt        <= '0;
            phase            <= 1'b1;
            led_array_export <= '0;
        end else begin
            if (wr_led)   led_data  <= avs_writedata[N_LED-1:0];
            if (wr_blink) led_blink <= avs_writedata[N_LED-1:0];
            if (wr_div) begin
                blink_div <= avs_writedata[DIV_W-1:0];
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (blink_div == '0) begin
                blink_cnt <= '0;
                phase     <= 1'b1;
            end else if (blink_cnt == blink_div) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + DIV_W'(1);
            end
            led_array_export <= led_data & ~(led_blink & {N_LED{~phase}});
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            3'd0:    rd_mux[N_LED-1:0] = led_data;
            3'd1:    rd_mux[N_LED-1:0] = led_blink;
            3'd2:    rd_mux[DIV_W-1:0] = blink_div;
            3'd3:    rd_mux[N_SW-1:0]  = stable;
            3'd4:    rd_mux[N_SW-1:0]  = edge_cap;
            3'd5:    rd_mux[N_SW-1:0]  = irq_mask;
            default: rd_mux = '0;
        endcase
    end

    // Registered from pre-edge state, so a read alongside a write returns the old value.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_led_switch_pio.sv
// Scoreboard bench for led_switch_pio: directed bus and switch stimulus, expectations queued
// and compared by a monitor on the falling edge.
module tb_led_switch_pio;

    localparam int N_LED = 8;
    localparam int N_SW  = 4;
    localparam int DEB   = 4;
    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       avs_address;
    logic             avs_read;
    logic             avs_write;
    logic [31:0]      avs_writedata;
    logic [31:0]      avs_readdata;
    logic [N_LED-1:0] led;
    logic [N_SW-1:0]  sw;
    logic             irq;

    always #5 clk = ~clk;

    led_switch_pio #(
        .N_LED(N_LED), .N_SW(N_SW), .DEB_CYCLES(DEB), .DIV_W(DIV_W), .EDGE_MODE(2)
    ) dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .avs_address      (avs_address),
        .avs_read         (avs_read),
        .avs_write        (avs_write),
        .avs_writedata    (avs_writedata),
        .avs_readdata     (avs_readdata),
        .led_array_export (led),
        .sw_array_export  (sw),
        .irq              (irq)
    );

    typedef struct {
        logic [31:0] exp;
        int          kind;
        string       name;
    } exp_t;

    exp_t rd_q[$];
    exp_t pin_q[$];
    int   checks = 0;
    int   errors = 0;
    logic rd_valid = 1'b0;
    logic probe = 1'b0;
    logic end_req = 1'b0;
    logic end_ack = 1'b0;

    always @(posedge clk) rd_valid <= avs_read;

    // kind: 0 = irq pin, 1 = LED pins, 2 = readdata holding
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        if (rd_valid) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow: read data %h with nothing expected", avs_readdata);
            end else begin
                e = rd_q.pop_front();
                if (avs_readdata !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", e.name, avs_readdata, e.exp);
                end
            end
        end
        if (probe) begin
            checks++;
            if (pin_q.size() == 0) begin
                errors++;
                $display("FAIL pin_underflow: probe with nothing expected");
            end else begin
                e = pin_q.pop_front();
                case (e.kind)
                    0:       act = {31'b0, irq};
                    1:       act = 32'(led);
                    default: act = avs_readdata;
                endcase
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h want %h", e.name, act, e.exp);
                end
            end
        end
        if (end_req && !end_ack) begin
            checks++;
            if (rd_q.size() != 0 || pin_q.size() != 0) begin
                errors++;
                $display("FAIL leftover: got %0d/%0d pending want 0/0", rd_q.size(), pin_q.size());
            end
            end_ack = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp = exp; e.kind = 0; e.name = name;
        rd_q.push_back(e);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic bus_rw(input logic [2:0] a, input logic [31:0] d, input logic [31:0] exp,
                          input string name);
        exp_t e;
        e.exp = exp; e.kind = 0; e.name = name;
        rd_q.push_back(e);
        avs_address   = a;
        avs_writedata = d;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        tick();
        avs_read  = 1'b0;
        avs_write = 1'b0;
    endtask

    // Checks the pin state left by the most recent clock edge.
    task automatic chk_pin(input int kind, input logic [31:0] exp, input string name);
        exp_t e;
        e.exp = exp; e.kind = kind; e.name = name;
        pin_q.push_back(e);
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; sw = '0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0;
        ticks(2);
        rst_n = 1'b1;

        chk_pin(2, 32'h0, "rst_readdata");
        chk_pin(1, 32'h0, "rst_led");
        chk_pin(0, 32'h0, "rst_irq");
        for (int a = 0; a < 6; a++) bus_read(3'(a), 32'h0, "rst_reg");

        // reset in the middle of a debounce with sw[0] held high
        rst_n = 1'b0;
        tick();
        sw = 4'b0001;
        rst_n = 1'b1;
        ticks(3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus_read(3'd3, 32'h0, "t1_sw_early");
        for (int i = 0; i < 5; i++) bus_read(3'd4, 32'h0, "t1_no_early_cap");
        bus_read(3'd4, 32'h1, "t1_cap_rise");
        bus_read(3'd3, 32'h1, "t1_sw_high");

        // W1C colliding with a new falling edge on bit 0
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, 32'h0, "t4_pre_clear");
        sw = 4'b0000;
        ticks(5);
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, 32'h1, "t4_set_wins");
        bus_read(3'd3, 32'h0, "t4_sw0_low");
        bus_write(3'd4, 32'h1);
        bus_read(3'd4, 32'h0, "t4_w1c");

        // 3-cycle glitch on sw[1] is rejected
        sw = 4'b0010;
        ticks(3);
        sw = 4'b0000;
        ticks(6);
        bus_read(3'd3, 32'h0, "t2_glitch_sw");
        bus_read(3'd4, 32'h0, "t2_glitch_cap");

        // edge capture and irq on sw[1]
        bus_write(3'd5, 32'h2);
        bus_read(3'd5, 32'h2, "t3_mask");
        sw = 4'b0010;
        ticks(5);
        bus_read(3'd3, 32'h0, "t3_sw_pre");
        chk_pin(0, 32'h0, "t3_irq_pre");
        chk_pin(0, 32'h1, "t3_irq_rise");
        bus_read(3'd3, 32'h2, "t3_sw_post");
        bus_read(3'd4, 32'h2, "t3_cap_rise");
        bus_write(3'd4, 32'h2);
        chk_pin(0, 32'h1, "t3_irq_lag");
        chk_pin(0, 32'h0, "t3_irq_clr");
        bus_read(3'd4, 32'h0, "t3_cap_clr");
        sw = 4'b0000;
        ticks(6);
        chk_pin(0, 32'h0, "t3_irq_fall_pre");
        chk_pin(0, 32'h1, "t3_irq_fall");
        bus_read(3'd4, 32'h2, "t3_cap_fall");
        bus_write(3'd4, 32'h2);
        bus_write(3'd5, 32'h0);

        // blink
        bus_write(3'd2, 32'hFFFF_FFFF);
        bus_read(3'd2, 32'h00FF_FFFF, "t5_div_width");
        bus_write(3'd0, 32'hFF);
        bus_write(3'd1, 32'h0F);
        bus_read(3'd1, 32'h0F, "t5_blink_mask");
        bus_write(3'd2, 32'h3);
        for (int i = 0; i < 5; i++) chk_pin(1, 32'hFF, "t5_led_on");
        for (int i = 0; i < 4; i++) chk_pin(1, 32'hF0, "t5_led_off");
        for (int i = 0; i < 4; i++) chk_pin(1, 32'hFF, "t5_led_on2");
        bus_write(3'd2, 32'h0);
        tick();
        for (int i = 0; i < 6; i++) chk_pin(1, 32'hFF, "t5_div0_const");

        // bus corner cases
        bus_read(3'd6, 32'h0, "t6_addr6");
        bus_write(3'd6, 32'hDEAD_BEEF);
        bus_read(3'd6, 32'h0, "t6_addr6_wr");
        bus_read(3'd7, 32'h0, "t6_addr7");
        bus_write(3'd0, 32'h1A5);
        chk_pin(1, 32'hFF, "t6_led_lag");
        chk_pin(1, 32'hA5, "t6_led_new");
        bus_read(3'd0, 32'hA5, "t6_trunc");
        bus_rw(3'd0, 32'h3C, 32'hA5, "t6_rw_old");
        chk_pin(2, 32'hA5, "t6_hold");
        chk_pin(2, 32'hA5, "t6_hold2");
        bus_read(3'd0, 32'h3C, "t6_rw_new");

        tick();
        end_req = 1'b1;
        for (int i = 0; i < 10 && !end_ack; i++) tick();
        if (!end_ack) begin
            $display("FAIL end_timeout: got no monitor ack want ack");
            $fatal(1, "end timeout");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
